// File: rtl/ysyx_reg_wport_arb.sv
// ============================================================================
// ysyx_reg_wport_arb
// ----------------------------------------------------------------------------
// Purpose:
//   This block owns the single write port of the integer register file.
//
//   1. Zeroing sweep. After reset, or after an init_req pulse, it writes zero
//      to every architectural register from x1 to x(REG_NUM-1), one register
//      per cycle. x0 is never written.
//   2. Arbitration. After the sweep it selects one of NREQ writeback
//      requesters each cycle. The selection is round-robin and uses
//      valid/ready handshakes.
//   3. Output stage. The selected write goes to the regfile through one
//      output register stage.
//
// Parameters:
//   XLEN     data width
//   REG_LEN  significant register-address bits (4 = RV32E, 5 = RV32I)
//   REG_NUM  architectural register count (2**REG_LEN)
//   NREQ     number of write requesters (2..4)
//
// Ports:
//   clock      clock
//   reset      asynchronous, active-low reset
//   init_req   synchronous request to restart the zeroing sweep
//   req_valid  [NREQ]       requester i has a write pending
//   req_ready  [NREQ]       requester i is accepted this cycle
//                           (combinational, one-hot or zero)
//   req_addr   [NREQ*5]     destination register per requester,
//                           slice i = [5i+4:5i]
//   req_data   [NREQ*XLEN]  write data per requester, slice i = [XLEN*i +: XLEN]
//   write_en   regfile write enable (registered)
//   waddr      [5]          regfile write address (registered)
//   wdata      [XLEN]       regfile write data (registered)
//   init_done  high while in RUN, i.e. the sweep has completed
//   busy       high in INIT, or while write_en is high
//   dbg_state  current FSM state (0 = INIT, 1 = RUN), for checkers
//
// Optional feature (macro YSYX_WPORT_BYPASS_EN):
//   This macro adds the operand-bypass ports rs1, rs2, byp1_valid, byp2_valid,
//   byp1_data and byp2_data. Each bypass port forwards the in-flight write
//   (write_en/waddr/wdata) to the operand read path in the same cycle.
//   During INIT the bypass reports the zero that is being written.
//
// Handshake:
//   A transfer from requester i happens in every cycle in which
//   req_valid[i] and req_ready[i] are both high.
//   - req_ready depends on req_valid, the round-robin pointer, the FSM state
//     and init_req.
//   - req_ready never depends on data or address.
//   - Requesters must hold valid, addr and data stable until they see ready.
//     The arbiter does not check this.
//   - A transfer accepted in cycle t appears on write_en/waddr/wdata in
//     cycle t+1.
// ============================================================================
module ysyx_reg_wport_arb #(
    parameter int XLEN    = 32,
    parameter int REG_LEN = 4,
    parameter int REG_NUM = 16,
    parameter int NREQ    = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 init_req,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*5-1:0]    req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic                 write_en,
    output logic [4:0]           waddr,
    output logic [XLEN-1:0]      wdata,
    output logic                 init_done,
    output logic                 busy,
    output logic [0:0]           dbg_state
`ifdef YSYX_WPORT_BYPASS_EN
    ,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    output logic                 byp1_valid,
    output logic                 byp2_valid,
    output logic [XLEN-1:0]      byp1_data,
    output logic [XLEN-1:0]      byp2_data
`endif
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // This is the last register written by the sweep. The FSM leaves INIT
    // right after it loads this value into the output register.
    localparam logic [REG_LEN-1:0] CNT_LAST  = REG_LEN'(REG_NUM - 1);
    localparam logic [REG_LEN-1:0] CNT_FIRST = REG_LEN'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]         state;
    logic [REG_LEN-1:0] sweep_cnt;
    logic [PTR_W-1:0]   rr_ptr;

    // ------------------------------------------------------------------------
    // Arbitration signals
    // ------------------------------------------------------------------------
    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   cand_idx;
    logic               grant_valid;
    logic [PTR_W-1:0]   ptr_next;
    logic [4:0]         sel_addr;
    logic [XLEN-1:0]    sel_data;
    logic               sel_is_x0;

    // ------------------------------------------------------------------------
    // Round-robin search
    // ------------------------------------------------------------------------
    // The search starts at rr_ptr and moves upward, wrapping around at NREQ.
    // The first valid requester found gets the grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_idx = PTR_W'((int'(rr_ptr) + k) % NREQ);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // A grant is only issued in RUN. init_req suppresses the grant, so no
    // handshake is lost when the sweep restarts.
    assign grant_valid = (state == ST_RUN) && !init_req && grant_found;

    always_comb begin
        req_ready = '0;
        if (grant_valid) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // The pointer moves to the slot after the winner, wrapping around at NREQ.
    always_comb begin
        if (int'(grant_idx) == NREQ - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + PTR_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Payload mux for the granted requester
    // ------------------------------------------------------------------------
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_addr = req_addr[i*5 +: 5];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Only the low REG_LEN bits decide whether the target is x0. The address
    // bits above REG_LEN still pass through to waddr unmodified.
    assign sel_is_x0 = (sel_addr[REG_LEN-1:0] == '0);

    // ------------------------------------------------------------------------
    // FSM, sweep counter, round-robin pointer and output register
    // ------------------------------------------------------------------------
    // When write_en is low, waddr and wdata hold their values. This keeps the
    // regfile inputs quiet between writes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_INIT;
            sweep_cnt <= CNT_FIRST;
            rr_ptr    <= '0;
            write_en  <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
        end else if (init_req) begin
            // Restart the sweep. A write that is already in the output
            // register completes this cycle. No new write is loaded behind it.
            state     <= ST_INIT;
            sweep_cnt <= CNT_FIRST;
            write_en  <= 1'b0;
        end else if (state == ST_INIT) begin
            write_en  <= 1'b1;
            waddr     <= 5'(sweep_cnt);
            wdata     <= '0;
            sweep_cnt <= sweep_cnt + CNT_FIRST;
            if (sweep_cnt == CNT_LAST) begin
                state <= ST_RUN;
            end
        end else begin
            if (grant_valid) begin
                rr_ptr <= ptr_next;
                if (sel_is_x0) begin
                    // A write to x0 is accepted but dropped.
                    write_en <= 1'b0;
                end else begin
                    write_en <= 1'b1;
                    waddr    <= sel_addr;
                    wdata    <= sel_data;
                end
            end else begin
                write_en <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------------
    assign init_done = (state == ST_RUN);
    assign busy      = (state == ST_INIT) || write_en;
    assign dbg_state = state;

`ifdef YSYX_WPORT_BYPASS_EN
    // ------------------------------------------------------------------------
    // Operand bypass
    // ------------------------------------------------------------------------
    // This forwards the write that the regfile captures at the end of this
    // cycle. Reads of x0 never hit, because x0 always reads as zero anyway.
    assign byp1_valid = write_en && (waddr == rs1) && (rs1 != 5'd0);
    assign byp2_valid = write_en && (waddr == rs2) && (rs2 != 5'd0);
    assign byp1_data  = wdata;
    assign byp2_data  = wdata;
`endif

endmodule
